// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/execute control unit: owns PC and IR, gates decoder clock
// enables to one pulse per instruction, and runs the data-memory handshake.
module fetch_exec_sequencer #(
  parameter int         INS_W    = 15,
  parameter int         PC_W     = 8,
  parameter logic [4:0] OP_LD_DM = 5'b11001,
  parameter logic [4:0] OP_ST_DM = 5'b11100,
  parameter logic [4:0] OP_HLT   = 5'b11111,
  parameter int         WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [INS_W-1:0] ins_in,
  output logic [PC_W-1:0]  pm_addr,
  output logic [INS_W-1:0] ir,
  input  logic             dec_reg_ce,
  input  logic             dec_accu_ce,
  input  logic             dec_carry_ce,
  input  logic             dec_dm_ce,
  output logic             reg_ce,
  output logic             accu_ce,
  output logic             carry_ce,
  output logic             dm_ce,
  output logic             dm_req,
  input  logic             dm_ack,
  output logic             halted,
  output logic             fault,
  output logic [15:0]      retired,
  output logic [2:0]       state
);

  localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    MEMWAIT = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [4:0]        opcode;
  logic              fire, wait_clr, wait_inc, set_fault;

  assign opcode = ir[INS_W-1 -: 5];

  always_comb begin
    nxt       = cur;
    fire      = 1'b0;
    dm_req    = 1'b0;
    wait_clr  = 1'b0;
    wait_inc  = 1'b0;
    set_fault = 1'b0;
    case (cur)
      IDLE:  if (run) nxt = FETCH;
      FETCH: nxt = EXEC;
      EXEC: begin
        if (opcode == OP_HLT) begin
          nxt = HALT;
        end else if (opcode == OP_LD_DM || opcode == OP_ST_DM) begin
          dm_req   = 1'b1;
          wait_clr = 1'b1;
          nxt      = MEMWAIT;
        end else begin
          fire = 1'b1;
          nxt  = run ? FETCH : IDLE;
        end
      end
      MEMWAIT: begin
        dm_req = 1'b1;
        if (dm_ack) begin
          fire = 1'b1;
          nxt  = run ? FETCH : IDLE;
        end else if (wait_cnt == WAIT_W'(WAIT_MAX)) begin
          set_fault = 1'b1;
          nxt       = HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  // Enables pass through only in the single retirement cycle.
  assign reg_ce   = fire & dec_reg_ce;
  assign accu_ce  = fire & dec_accu_ce;
  assign carry_ce = fire & dec_carry_ce;
  assign dm_ce    = fire & dec_dm_ce;
  assign halted   = (cur == HALT);
  assign state    = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= IDLE;
      pm_addr  <= '0;
      ir       <= '0;
      retired  <= '0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (cur == FETCH) ir <= ins_in;
      if (fire) begin
        pm_addr <= pm_addr + 1'b1;
        if (retired != '1) retired <= retired + 1'b1;
      end
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
      if (set_fault) fault <= 1'b1;
    end
  end

endmodule

// File: doc/fetch_exec_sequencer.md
Name: fetch_exec_sequencer

Overview:
Multi-cycle control unit for the 8-bit core. It owns the program counter and the instruction register, and feeds the instruction decoder. It gates the decoder's clock-enable outputs so that register, accumulator, carry and data-memory writes fire exactly once per instruction. It also handles the data-memory request/acknowledge handshake, pause/resume, halt and memory-timeout fault.

Parameters:
INS_W, 15, instruction width; opcode = ir[INS_W-1:INS_W-5], data = ir[7:0]
PC_W, 8, program counter width; program memory depth = 2**PC_W
OP_LD_DM, 5'b11001, opcode of load-from-data-memory
OP_ST_DM, 5'b11100, opcode of store-to-data-memory
OP_HLT, 5'b11111, halt opcode (reserved slot in the REST section)
WAIT_MAX, 15, maximum MEMWAIT cycles before a fault

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  1 = execute; 0 = pause at the next instruction boundary
ins_in  in  INS_W  instruction from program memory (combinational read of pm_addr)
pm_addr  out  PC_W  program counter / program memory address
ir  out  INS_W  instruction register, drives the decoder Ins input
dec_reg_ce  in  1  decoder Reg_CE
dec_accu_ce  in  1  decoder Accu_CE
dec_carry_ce  in  1  decoder Carry_CE
dec_dm_ce  in  1  decoder DataMem_CE
reg_ce  out  1  gated register-file enable
accu_ce  out  1  gated accumulator enable
carry_ce  out  1  gated carry enable
dm_ce  out  1  gated data-memory write enable
dm_req  out  1  data-memory access request
dm_ack  in  1  data-memory access complete
halted  out  1  core stopped by HLT or fault
fault  out  1  memory timeout occurred
retired  out  16  count of retired instructions, saturates at 16'hFFFF
state  out  3  current FSM state (debug)

Behaviour:
- Reset values: state=IDLE; pm_addr=0; ir=0; retired=0; halted=0; fault=0; wait counter=0. All CE outputs and dm_req are 0.
- States: IDLE=0, FETCH=1, EXEC=2, MEMWAIT=3, HALT=4.
- IDLE:
  - Leave to FETCH when run=1; otherwise stay in IDLE.
  - pm_addr is held, so resume continues at the paused PC.
- FETCH: at the clock edge, ir <= ins_in. Go to EXEC.
- EXEC, opcode OP_HLT:
  - No CE is asserted; pm_addr is not incremented; retired is not incremented.
  - Go to HALT.
- EXEC, opcode OP_LD_DM or OP_ST_DM:
  - dm_req=1 (combinational from the state); no CEs.
  - Go to MEMWAIT with the wait counter cleared.
  - dm_ack is ignored in EXEC.
- EXEC, any other opcode (retirement):
  - "Fire" means reg_ce=dec_reg_ce, accu_ce=dec_accu_ce, carry_ce=dec_carry_ce, dm_ce=dec_dm_ce, for this cycle only.
  - At the edge: pm_addr += 1, retired += 1 (saturating).
  - Go to FETCH if run=1, else to IDLE.
- MEMWAIT:
  - dm_req=1 throughout.
  - If dm_ack=1: fire the CEs as in EXEC, pm_addr += 1, retired += 1, then go to FETCH if run=1, else to IDLE.
  - Else, if wait counter == WAIT_MAX: set fault=1 and go to HALT; no CEs fire, PC is unchanged.
  - Else: wait counter += 1.
- HALT: halted=1 and all enables are 0. Leave only via rst; run is ignored.
- Outside the firing cycle, every CE output is 0 regardless of the dec_* inputs.
- PC wrap: at 2**PC_W-1 the increment wraps to 0 with no flag.
- Latency: a non-memory instruction takes 2 cycles. A memory instruction takes 3+N cycles, where N = cycles dm_ack stays low in MEMWAIT.
- run deasserted mid-instruction: the current instruction always completes. The pause takes effect only at the retire edge.
- Asynchronous rst in any state (including MEMWAIT with dm_req high): immediate return to the reset values; dm_req drops without waiting for dm_ack.

Test Plan:
- Reset, run=1, program ALU-only ops at addresses 0..3 (opcode 00000, dec_accu_ce=1) -> FETCH/EXEC alternate; accu_ce pulses once every 2 cycles; pm_addr counts 0,1,2,3; retired=4 after 8 cycles.
- ST_DM at address 5 (15'b11100_00_00010010), dm_ack asserted 3 cycles after entering MEMWAIT -> dm_req high for 1 EXEC + 4 MEMWAIT cycles; dm_ce pulses exactly once in the ack cycle; pm_addr goes 5 -> 6; total 6 cycles.
- LD_DM with dm_ack never asserted, WAIT_MAX=15 -> after 16 MEMWAIT cycles fault=1, halted=1, pm_addr unchanged, no CE pulse ever.
- run dropped during EXEC of the instruction at address 2 -> that instruction retires, state=IDLE, pm_addr=3, stays there. Raise run again -> FETCH at 3.
- HLT at address 7 -> halted=1, pm_addr=7, retired unchanged; toggling run has no effect; asserting rst clears everything to 0.
- PC_W=8, pm_addr=255 executing an ALU op -> pm_addr wraps to 0. Pulse rst during MEMWAIT -> dm_req drops to 0 asynchronously, state=IDLE.
